// File: rtl/neuron_pkg.sv
// Shared types, default parameters and arithmetic helpers for the neuron_vec datapath.
package neuron_pkg;

  localparam int DEF_IN_WIDTH   = 4;
  localparam int DEF_W_WIDTH    = 4;
  localparam int DEF_LANES      = 4;
  localparam int DEF_NUM_INPUTS = 784;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_SHIFT      = 6;
  localparam int DEF_OUT_WIDTH  = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Helpers work on a 64-bit signed carrier so they serve any width up to 62.
  typedef struct packed {
    logic [63:0] value;
    logic        sat;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int width);
    sat_res_t          r;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    r.value = s;
    r.sat   = 1'b0;
    if (s > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (s < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

  // ReLU zeroing of a negative value is not reported as a clip.
  function automatic sat_res_t clip_out(input logic signed [63:0] v,
                                        input int width,
                                        input logic relu);
    sat_res_t          r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r.value = v;
    r.sat   = 1'b0;
    if (relu) begin
      hi = (64'sd1 <<< width) - 64'sd1;
      if (v < 64'sd0) begin
        r.value = '0;
      end else if (v > hi) begin
        r.value = hi;
        r.sat   = 1'b1;
      end
    end else begin
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
        r.value = hi;
        r.sat   = 1'b1;
      end else if (v < lo) begin
        r.value = lo;
        r.sat   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_dot_lanes.sv
// Combinational per-beat dot product: LANES unsigned x signed multipliers feeding a binary adder tree.
module neuron_dot_lanes
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [LANES*IN_WIDTH-1:0]  data_in,
  input  logic [LANES*W_WIDTH-1:0]   weight_in,
  output logic signed [ACC_WIDTH-1:0] beat_sum
);

  localparam int PROD_W = IN_WIDTH + 1 + W_WIDTH;
  localparam int LEAVES = 1 << $clog2(LANES);
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: node 0 is the root, leaves start at LEAVES-1.
  logic signed [ACC_WIDTH-1:0] node [NODES];

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < LANES) begin : g_mul
        logic signed [IN_WIDTH:0]   a;
        logic signed [W_WIDTH-1:0]  b;
        logic signed [PROD_W-1:0]   p;
        assign a = signed'({1'b0, data_in[gi*IN_WIDTH +: IN_WIDTH]});
        assign b = signed'(weight_in[gi*W_WIDTH +: W_WIDTH]);
        assign p = PROD_W'(a) * PROD_W'(b);
        assign node[LEAVES-1+gi] = ACC_WIDTH'(p);
      end else begin : g_pad
        assign node[LEAVES-1+gi] = '0;
      end
    end
    for (gi = 0; gi < LEAVES - 1; gi++) begin : g_add
      assign node[gi] = node[2*gi+1] + node[2*gi+2];
    end
  endgenerate

  assign beat_sum = node[0];

endmodule

// File: rtl/neuron_vec.sv
// Streaming neuron: accumulates a NUM_INPUTS-long weighted sum LANES pairs per beat,
// then rounds, shifts and clips to an OUT_WIDTH activation held until taken.
module neuron_vec
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int W_WIDTH    = DEF_W_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*IN_WIDTH-1:0]   data_in,
  input  logic [LANES*W_WIDTH-1:0]    weight_in,
  input  logic signed [ACC_WIDTH-1:0] bias_in,
  input  logic                        relu_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic signed [63:0] ROUND = (64'sd1 <<< SHIFT) >>> 1;

  generate
    if (NUM_INPUTS % LANES != 0) begin : g_bad_len
      $error("neuron_vec: NUM_INPUTS must be a multiple of LANES");
    end
    if (ACC_WIDTH > 62 || SHIFT < 0 || SHIFT > ACC_WIDTH - 2) begin : g_bad_acc
      $error("neuron_vec: ACC_WIDTH or SHIFT out of range");
    end
  endgenerate

  state_t                      state_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic [CW-1:0]               beat_reg;
  logic                        relu_reg;
  logic                        acc_sat_reg;
  logic [OUT_WIDTH-1:0]        out_data_reg;
  logic                        out_sat_reg;
  logic                        out_valid_reg;
  logic [1:0]                  rst_sync_reg;

  logic signed [ACC_WIDTH-1:0] beat_sum;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [63:0]          norm;
  sat_res_t                    add_res;
  sat_res_t                    clip_res;
  logic                        first_beat;
  logic                        last_beat;
  logic                        mode;
  logic                        sat_any;
  logic                        rst_busy;
  logic                        accept;
  logic                        unused_bits;

  neuron_dot_lanes #(
    .IN_WIDTH (IN_WIDTH),
    .W_WIDTH  (W_WIDTH),
    .LANES    (LANES),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_dot (
    .data_in  (data_in),
    .weight_in(weight_in),
    .beat_sum (beat_sum)
  );

  // Bias and mode come straight from the ports on beat 0, from the latched copies afterwards.
  always_comb begin
    first_beat = (beat_reg == '0);
    last_beat  = (beat_reg == CW'(BEATS - 1));
    base       = first_beat ? bias_in : acc_reg;
    add_res    = sat_add(64'(base), 64'(beat_sum), ACC_WIDTH);
    acc_next   = ACC_WIDTH'(add_res.value);
    sat_any    = add_res.sat | (~first_beat & acc_sat_reg);
    mode       = first_beat ? relu_en : relu_reg;
    norm       = (64'(acc_next) + ROUND) >>> SHIFT;
    clip_res   = clip_out(norm, OUT_WIDTH, mode);
  end

  assign unused_bits = ^{add_res.value[63:ACC_WIDTH], clip_res.value[63:OUT_WIDTH]};

  // Beats are refused for two edges after reset release so the release is clk-aligned.
  assign rst_busy  = rst_sync_reg[1];
  assign in_ready  = (state_reg == ST_ACCUM) && !rst_busy;
  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_ACCUM;
      acc_reg       <= '0;
      beat_reg      <= '0;
      relu_reg      <= 1'b0;
      acc_sat_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      rst_sync_reg  <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
      case (state_reg)
        ST_ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              out_data_reg  <= clip_res.value[OUT_WIDTH-1:0];
              out_sat_reg   <= clip_res.sat | sat_any;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_HOLD;
              acc_reg       <= '0;
              beat_reg      <= '0;
              acc_sat_reg   <= 1'b0;
            end else begin
              acc_reg     <= acc_next;
              beat_reg    <= beat_reg + CW'(1);
              acc_sat_reg <= sat_any;
              relu_reg    <= mode;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_ACCUM;
          end
        end
        default: state_reg <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_vec.sv
// Directed-vector bench for neuron_vec with a small reference model for the random vectors.
module tb_neuron_vec;

  localparam int IN_WIDTH   = 4;
  localparam int W_WIDTH    = 4;
  localparam int LANES      = 4;
  localparam int NUM_INPUTS = 784;
  localparam int ACC_WIDTH  = 24;
  localparam int SHIFT      = 6;
  localparam int OUT_WIDTH  = 4;
  localparam int BEATS      = NUM_INPUTS / LANES;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [LANES*IN_WIDTH-1:0]   data_in;
  logic [LANES*W_WIDTH-1:0]    weight_in;
  logic signed [ACC_WIDTH-1:0] bias_in;
  logic                        relu_en;
  logic                        in_valid;
  logic                        in_ready;
  logic [OUT_WIDTH-1:0]        out_data;
  logic                        out_sat;
  logic                        out_valid;
  logic                        out_ready;

  always #5 clk = ~clk;

  neuron_vec #(
    .IN_WIDTH  (IN_WIDTH),
    .W_WIDTH   (W_WIDTH),
    .LANES     (LANES),
    .NUM_INPUTS(NUM_INPUTS),
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .weight_in(weight_in),
    .bias_in  (bias_in),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_pulses = 0;

  logic [IN_WIDTH-1:0]        dat [BEATS][LANES];
  logic signed [W_WIDTH-1:0]  wgt [BEATS][LANES];

  always @(negedge clk) if (out_valid) valid_pulses++;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_uniform(input int d, input int w);
    for (int b = 0; b < BEATS; b++)
      for (int k = 0; k < LANES; k++) begin
        dat[b][k] = IN_WIDTH'(d);
        wgt[b][k] = W_WIDTH'(w);
      end
  endtask

  task automatic fill_random();
    for (int b = 0; b < BEATS; b++)
      for (int k = 0; k < LANES; k++) begin
        dat[b][k] = IN_WIDTH'($urandom_range(0, 15));
        wgt[b][k] = W_WIDTH'($urandom_range(0, 15));
      end
  endtask

  function automatic void model(input longint bias, input bit relu, output int od, output int os);
    longint acc;
    longint s;
    longint norm;
    bit     sat;
    acc = bias;
    sat = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      s = 0;
      for (int k = 0; k < LANES; k++) s += longint'(dat[b][k]) * longint'(wgt[b][k]);
      acc += s;
      if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1'b1; end
      if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1'b1; end
    end
    norm = (acc + 32) >>> 6;
    os = int'(sat);
    if (relu) begin
      if (norm < 0) od = 0;
      else if (norm > 15) begin od = 15; os = 1; end
      else od = int'(norm);
    end else begin
      if (norm < -8) begin od = 8; os = 1; end
      else if (norm > 7) begin od = 7; os = 1; end
      else od = int'(norm) & 15;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the final beat's accepting edge.
  task automatic drive_beats(input int n_beats, input bit gaps, input longint bias, input bit relu);
    for (int b = 0; b < n_beats; b++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
          in_valid = 1'b0;
          data_in  = 16'($urandom);
          bias_in  = 24'($urandom);
          relu_en  = ~relu;
          @(posedge clk); @(negedge clk);
        end
      end
      for (int k = 0; k < LANES; k++) begin
        data_in[k*IN_WIDTH +: IN_WIDTH] = dat[b][k];
        weight_in[k*W_WIDTH +: W_WIDTH] = wgt[b][k];
      end
      bias_in  = (b == 0) ? 24'(bias) : 24'($urandom);
      relu_en  = (b == 0) ? relu : ~relu;
      in_valid = 1'b1;
      if (b == 0) check_eq("ready_first_beat", longint'(in_ready), 1);
      if (b == n_beats - 1) check_eq("no_early_valid", longint'(out_valid), 0);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input int idx, input longint bias, input bit relu, input bit gaps,
                            input int exp_d, input int exp_s);
    drive_beats(BEATS, gaps, bias, relu);
    $display("vector %0d: bias=%0d relu=%0b out_valid=%0b out_data=%0d out_sat=%0b (want %0d/%0d)",
             idx, bias, relu, out_valid, out_data, out_sat, exp_d, exp_s);
    check_eq($sformatf("v%0d_out_valid", idx), longint'(out_valid), 1);
    check_eq($sformatf("v%0d_out_data", idx), longint'(out_data), exp_d);
    check_eq($sformatf("v%0d_out_sat", idx), longint'(out_sat), exp_s);
    @(posedge clk); @(negedge clk);
    check_eq($sformatf("v%0d_valid_drop", idx), longint'(out_valid), 0);
    check_eq($sformatf("v%0d_ready_back", idx), longint'(in_ready), 1);
  endtask

  int     t_d  [12] = '{1, 15, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  int     t_w  [12] = '{1, 7, -8, -1, 0, 0, 0, 0, 0, 0, 0, -1};
  longint t_b  [12] = '{0, 0, 0, 0, 32, 31, -33, 448, 480, 960, 992, -8388608};
  bit     t_r  [12] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
  int     t_ed [12] = '{12, 15, 0, 8, 1, 0, 15, 7, 7, 15, 15, 0};
  int     t_es [12] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1};

  initial begin
    int     stable_cnt;
    int     od;
    int     os;
    longint rb;
    bit     rr;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; weight_in = '0; bias_in = '0; relu_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_data", longint'(out_data), 0);
    check_eq("rst_out_sat", longint'(out_sat), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("ready_after_rst", longint'(in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      fill_uniform(t_d[i], t_w[i]);
      run_vector(i, t_b[i], t_r[i], (i % 3 == 1), t_ed[i], t_es[i]);
    end

    // Downstream stalls for 10 cycles while upstream keeps offering beats.
    fill_uniform(1, 1);
    out_ready = 1'b0;
    drive_beats(BEATS, 1'b0, -400, 1'b0);
    $display("hold vector: out_valid=%0b out_data=%0d out_sat=%0b", out_valid, out_data, out_sat);
    check_eq("hold_out_valid", longint'(out_valid), 1);
    check_eq("hold_out_data", longint'(out_data), 6);
    check_eq("hold_out_sat", longint'(out_sat), 0);
    stable_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      data_in  = 16'($urandom);
      @(posedge clk); @(negedge clk);
      if (out_valid && out_data == 4'd6 && !out_sat && !in_ready) stable_cnt++;
    end
    in_valid = 1'b0;
    check_eq("hold_stable_cycles", stable_cnt, 10);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("hold_released", longint'(out_valid), 0);
    fill_uniform(1, 1);
    run_vector(12, 0, 1'b1, 1'b0, 12, 0);

    // Abort a vector with reset at beat 100; nothing may come out.
    fill_random();
    valid_pulses = 0;
    drive_beats(100, 1'b1, 500, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_out_valid", longint'(out_valid), 0);
    check_eq("rst_mid_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_no_pulse", valid_pulses, 0);
    check_eq("rst_mid_out_data", longint'(out_data), 0);

    for (int i = 0; i < 2; i++) begin
      fill_random();
      rb = longint'($urandom_range(0, 4000)) - 2000;
      rr = (i == 0);
      model(rb, rr, od, os);
      run_vector(13 + i, rb, rr, 1'b1, od, os);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neuron_vec.md
NEURON_VEC -- requirements
Module: neuron_vec

Interface
REQ-001 Parameter IN_WIDTH, default 4: activation width per lane; activations are unsigned.
REQ-002 Parameter W_WIDTH, default 4: weight width per lane; weights are signed two's complement.
REQ-003 Parameter LANES, default 4: number of input/weight pairs consumed per accepted beat.
REQ-004 Parameter NUM_INPUTS, default 784: vector length; SHALL be a multiple of LANES, elaboration error otherwise.
REQ-005 Parameter ACC_WIDTH, default 24: signed accumulator width.
REQ-006 Parameter SHIFT, default 6: normalisation right-shift, range 0..ACC_WIDTH-2.
REQ-007 Parameter OUT_WIDTH, default 4: output activation width.
REQ-008 clk  input  1  single clock; all state changes on rising edge.
REQ-009 rst  input  1  reset; asynchronous and active-high.
REQ-010 data_in  input  LANES*IN_WIDTH  lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-011 weight_in  input  LANES*W_WIDTH  lane k occupies bits [k*W_WIDTH +: W_WIDTH].
REQ-012 bias_in  input  ACC_WIDTH  signed bias; sampled on the first beat of each vector.
REQ-013 relu_en  input  1  1 = ReLU/unsigned output, 0 = signed saturated output; sampled on the first beat.
REQ-014 in_valid  input  1  beat valid.
REQ-015 in_ready  output  1  beat accepted on clk edge when in_valid && in_ready.
REQ-016 out_data  output  OUT_WIDTH  result activation.
REQ-017 out_sat  output  1  result was clipped, valid with out_data.
REQ-018 out_valid  output  1  result valid.
REQ-019 out_ready  input  1  downstream accepts the result on clk edge when out_valid && out_ready.

Function
REQ-020 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-021 Each lane product SHALL be signed({1'b0,data}) * signed(weight), sign-extended to ACC_WIDTH; the beat sum SHALL be the sum of all LANES products.
REQ-022 The accumulator SHALL load bias_in + beat sum on beat 0 and add the beat sum on beats 1..NUM_INPUTS/LANES-1.
REQ-023 Accumulator addition SHALL saturate at signed ACC_WIDTH bounds, never wrap; saturation SHALL force out_sat for that vector.
REQ-024 On acceptance of the last beat: final = acc + beat sum; norm = (final + 2^(SHIFT-1)) >>> SHIFT, round-half-up, with no rounding term when SHIFT=0.
REQ-025 relu_en=1: norm<0 -> 0; norm>2^OUT_WIDTH-1 -> 2^OUT_WIDTH-1; else norm.
REQ-026 relu_en=0: clip norm to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], two's complement.
REQ-027 out_sat SHALL be 1 if a positive or negative clip occurred in REQ-025/026 or REQ-023 fired; ReLU zeroing of a negative value SHALL NOT count as a clip.
REQ-028 Latency: out_valid SHALL rise on the same edge that accepts the last beat; the FSM enters HOLD.
REQ-029 In HOLD, out_data and out_sat SHALL remain stable until out_valid && out_ready; on that edge the FSM returns to ACCUM and the accumulator and beat counter clear.
REQ-030 Throughput SHALL be one vector per NUM_INPUTS/LANES + 1 cycles when out_ready is held at 1.
REQ-031 Gaps in in_valid within a vector SHALL hold all state unchanged.
REQ-032 in_valid asserted during HOLD SHALL be ignored; no beat is consumed.
REQ-033 relu_en and bias_in changes after beat 0 SHALL have no effect on the current vector.

Reset
REQ-034 Asserting rst SHALL immediately clear the accumulator, beat counter, latched mode, out_data, out_sat and out_valid to 0 and set the state to ACCUM; release SHALL be synchronised to clk.
REQ-035 rst mid-vector or mid-HOLD SHALL discard the partial or pending result with no output.

Structure
REQ-036 Package neuron_pkg SHALL hold the state enum, default parameter constants, and the saturating-add and clip helper functions.
REQ-037 Sub-module neuron_dot_lanes SHALL implement the LANES multipliers plus adder tree, combinationally; neuron_vec instantiates it once.

Verification
REQ-038 Defaults, all data=1, all weights=1, bias=0, relu_en=1: sum 784, norm 12 -> out_data=12, out_sat=0, out_valid one edge after the 196th beat.
REQ-039 All data=15, weights=7: final 82320, norm 1286 -> out_data=15, out_sat=1; with weights=-8 -> out_data=0, out_sat=0.
REQ-040 relu_en=0, weights=-1, data=1, bias=0: norm -12 -> out_data=4'b1000 (-8), out_sat=1.
REQ-041 out_ready=0 for 10 cycles in HOLD: out_data stable, in_ready=0, extra in_valid ignored; the next vector computes correctly.
REQ-042 Random in_valid gaps plus rst asserted at beat 100: out_valid never pulses, and the following full vector matches the reference-model result.
